// File: rtl/rtmq_flow_sequencer_if.sv
// rtmq_flow_sequencer_if
// Bundles every non-clock/reset signal of the RTMQ flow sequencer.
//   master : the sequencer (drives fetch, issue, hold and stack status)
//   slave  : the surroundings (instruction memory, ALU, branch unit, host)
// Parameters must match the ones given to rtmq_flow_sequencer.
interface rtmq_flow_sequencer_if #(
  parameter int W_REG = 32,
  parameter int W_PC  = 16,
  parameter int D_STK = 8
);
  localparam int LW = $clog2(D_STK) + 1;

  logic [W_PC-1:0]  if_adr;
  logic             f_ftc;
  logic [W_REG-1:0] if_ins;
  logic [W_REG-1:0] instr;
  logic [W_PC-1:0]  reg_ptr;
  logic             f_hld;
  logic             f_rsm;
  logic             f_cfg;
  logic [W_REG-1:0] cfg_ins;
  logic             br_vld;
  logic [W_PC-1:0]  br_tgt;
  logic             br_call;
  logic             br_ret;
  logic [W_PC-1:0]  br_lnk;
  logic [LW-1:0]    stk_lvl;
  logic             stk_err;
  logic             tmo_flg;

  modport master (
    output if_adr, f_ftc, instr, reg_ptr, f_hld, stk_lvl, stk_err, tmo_flg,
    input  if_ins, f_rsm, f_cfg, cfg_ins, br_vld, br_tgt, br_call, br_ret, br_lnk
  );

  modport slave (
    input  if_adr, f_ftc, instr, reg_ptr, f_hld, stk_lvl, stk_err, tmo_flg,
    output if_ins, f_rsm, f_cfg, cfg_ins, br_vld, br_tgt, br_call, br_ret, br_lnk
  );
endinterface

// File: rtl/rtmq_flow_sequencer.sv
// rtmq_flow_sequencer
// Issues instruction fetch addresses, delivers fetched words to the RTMQ ALU
// and tracks the address of each issued word. Supports resolved-branch
// redirection over an N_PLM-cycle memory, a call/return stack, and a
// replay-based hold / configuration-override resume.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : rtmq_flow_sequencer_if.master
//              fetch   : if_adr, f_ftc -> memory; if_ins <- memory
//              issue   : instr, reg_ptr -> ALU
//              hold    : f_hld out; f_rsm, f_cfg, cfg_ins in
//              branch  : br_vld, br_tgt, br_call, br_ret, br_lnk in
//              status  : stk_lvl, stk_err, tmo_flg out
// Optional: define RTMQ_HOLD_WDT_EN to add the W_TMO-bit hold watchdog
// (forces a resume after 2^W_TMO hold cycles and sets tmo_flg).
module rtmq_flow_sequencer #(
  parameter int               W_REG = 32,
  parameter int               W_PC  = 16,
  parameter int               N_PLM = 3,
  parameter int               D_STK = 8,
  parameter int               P_HLD = 29,
  parameter int               P_FCT = 28,
  parameter logic [W_REG-1:0] I_NOP = '0,
  parameter int               W_TMO = 16
) (
  input  logic clk,
  input  logic rst,
  rtmq_flow_sequencer_if.master bus
);
  localparam int            SW       = $clog2(D_STK);
  localparam int            LW       = SW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(D_STK);

  // fetch / issue state
  logic [N_PLM-1:0]           vld_pipe;  // tag per in-flight fetch
  logic [N_PLM-1:0][W_PC-1:0] adr_pipe;  // address of each in-flight fetch
  logic [W_PC-1:0]            if_adr_q, reg_ptr_q, rsm_adr;
  logic                       f_ftc_q, f_hld_q, iss_vld;
  logic [W_REG-1:0]           instr_q;

  // return stack
  logic [D_STK-1:0][W_PC-1:0] stk;
  logic [SW-1:0]              sp;        // next free slot
  logic [LW-1:0]              lvl;
  logic                       stk_err_q;

  logic wdt_exp;

  // ---------------- control decode ----------------
  logic            hld_set, fct_set, gate, br_fetch, flush, issue;
  logic            do_push, do_pop, stk_emp;
  logic [SW-1:0]   top_idx;
  logic [W_PC-1:0] pop_tgt, br_dst;

  // An issued word's flags only count when it came from memory (iss_vld).
  assign hld_set  = iss_vld & instr_q[P_HLD];
  assign fct_set  = iss_vld & instr_q[P_FCT];
  // No fetching next cycle while held, overridden, or entering hold.
  assign gate     = f_hld_q | bus.f_cfg | hld_set;
  assign br_fetch = bus.br_vld & ~gate;
  assign flush    = br_fetch | fct_set;
  assign issue    = vld_pipe[N_PLM-1] & ~flush & ~gate;

  assign do_push  = bus.br_vld & bus.br_call;
  assign do_pop   = bus.br_vld & bus.br_ret;
  assign stk_emp  = (lvl == '0);
  assign top_idx  = sp - 1'b1;
  assign pop_tgt  = stk_emp ? '0 : stk[top_idx];
  assign br_dst   = bus.br_ret ? pop_tgt : bus.br_tgt;

  // ---------------- fetch ----------------
  // Restart after hold/cfg/reset replays from rsm_adr; no skid buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_adr_q <= '0;
      f_ftc_q  <= 1'b0;
    end else begin
      f_ftc_q <= ~gate;
      if (!gate) begin
        if (br_fetch)     if_adr_q <= br_dst;
        else if (fct_set) if_adr_q <= reg_ptr_q + 1'b1;
        else if (f_ftc_q) if_adr_q <= if_adr_q + 1'b1;
        else              if_adr_q <= rsm_adr;
      end
    end
  end

  // ---------------- tracker and address delay line ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      adr_pipe <= '0;
    end else begin
      for (int i = N_PLM-1; i > 0; i--) begin
        vld_pipe[i] <= vld_pipe[i-1];
        adr_pipe[i] <= adr_pipe[i-1];
      end
      vld_pipe[0] <= f_ftc_q;
      adr_pipe[0] <= if_adr_q;
      if (flush || gate) vld_pipe <= '0;
    end
  end

  // ---------------- issue ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q   <= I_NOP;
      reg_ptr_q <= '0;
      iss_vld   <= 1'b0;
      rsm_adr   <= '0;
    end else begin
      iss_vld <= issue;
      if (bus.f_cfg)  instr_q <= bus.cfg_ins;
      else if (issue) instr_q <= bus.if_ins;
      else            instr_q <= I_NOP;
      if (issue) reg_ptr_q <= adr_pipe[N_PLM-1];
      // resume point: word after the last valid issue, or a resolved branch
      if (bus.br_vld)   rsm_adr <= br_dst;
      else if (iss_vld) rsm_adr <= reg_ptr_q + 1'b1;
    end
  end

  // ---------------- hold ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         f_hld_q <= 1'b0;
    else if (hld_set)                f_hld_q <= 1'b1;
    else if (bus.f_rsm || wdt_exp)   f_hld_q <= 1'b0;
  end

  // ---------------- return stack ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp        <= '0;
      lvl       <= '0;
      stk_err_q <= 1'b0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          sp <= sp + 1'b1;              // full: wraps onto the oldest entry
          if (lvl == LVL_FULL) stk_err_q <= 1'b1;
          else                 lvl <= lvl + 1'b1;
        end
        2'b01: begin
          if (stk_emp) stk_err_q <= 1'b1;
          else begin
            sp  <= top_idx;
            lvl <= lvl - 1'b1;
          end
        end
        2'b11: begin
          if (stk_emp) begin            // nothing to swap: behave as push
            sp        <= sp + 1'b1;
            lvl       <= LW'(1);
            stk_err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage needs no reset: an empty level makes the contents unreachable.
  always_ff @(posedge clk) begin
    if (do_push) begin
      if (do_pop && !stk_emp) stk[top_idx] <= bus.br_lnk;  // swap top
      else                    stk[sp]      <= bus.br_lnk;
    end
  end

  // ---------------- hold watchdog ----------------
`ifdef RTMQ_HOLD_WDT_EN
  logic [W_TMO-1:0] tmo_cnt;
  logic             tmo_q;

  assign wdt_exp = f_hld_q & (&tmo_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      tmo_q   <= 1'b0;
    end else begin
      tmo_cnt <= f_hld_q ? tmo_cnt + 1'b1 : '0;
      if (wdt_exp) tmo_q <= 1'b1;
    end
  end

  assign bus.tmo_flg = tmo_q;
`else
  assign wdt_exp     = 1'b0;
  // W_TMO only sizes the watchdog; this expression is constant 0.
  assign bus.tmo_flg = (W_TMO < 0);
`endif

  assign bus.if_adr  = if_adr_q;
  assign bus.f_ftc   = f_ftc_q;
  assign bus.instr   = instr_q;
  assign bus.reg_ptr = reg_ptr_q;
  assign bus.f_hld   = f_hld_q;
  assign bus.stk_lvl = lvl;
  assign bus.stk_err = stk_err_q;
endmodule

// File: tb/tb_rtmq_flow_sequencer.sv
module tb_rtmq_flow_sequencer;
  localparam int W_REG = 32, W_PC = 16, N_PLM = 3, D_STK = 2, W_TMO = 4;
  localparam int P_HLD = 29, P_FCT = 28;
  localparam logic [W_REG-1:0] NOP = '0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rtmq_flow_sequencer_if #(.W_REG(W_REG), .W_PC(W_PC), .D_STK(D_STK)) bus ();

  rtmq_flow_sequencer #(
    .W_REG(W_REG), .W_PC(W_PC), .N_PLM(N_PLM), .D_STK(D_STK),
    .P_HLD(P_HLD), .P_FCT(P_FCT), .I_NOP(NOP), .W_TMO(W_TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [W_PC-1:0] hold_adr = 16'hFFFF;
  logic [W_PC-1:0] fct_adr  = 16'hFFFF;

  // memory image: address in low bits, flags only at the marked addresses
  function automatic logic [W_REG-1:0] word_of(input logic [W_PC-1:0] a, h, f);
    logic [W_REG-1:0] v;
    v = 32'h0A00_0000 | {16'h0, a};
    if (a == h) v[P_HLD] = 1'b1;
    if (a == f) v[P_FCT] = 1'b1;
    return v;
  endfunction

  function automatic logic [W_REG-1:0] w(input logic [W_PC-1:0] a);
    return word_of(a, hold_adr, fct_adr);
  endfunction

  // N_PLM-cycle instruction memory
  logic [N_PLM-1:0][W_PC-1:0] mem_pipe = '0;
  always @(posedge clk) begin
    mem_pipe[0] <= bus.if_adr;
    for (int i = 1; i < N_PLM; i++) mem_pipe[i] <= mem_pipe[i-1];
  end
  assign bus.if_ins = word_of(mem_pipe[N_PLM-1], hold_adr, fct_adr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [W_REG-1:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_if_adr"},  32'(bus.if_adr),  32'h0);
    chk({tag, "_f_ftc"},   32'(bus.f_ftc),   32'h0);
    chk({tag, "_instr"},   bus.instr,        NOP);
    chk({tag, "_reg_ptr"}, 32'(bus.reg_ptr), 32'h0);
    chk({tag, "_f_hld"},   32'(bus.f_hld),   32'h0);
    chk({tag, "_stk_lvl"}, 32'(bus.stk_lvl), 32'h0);
    chk({tag, "_stk_err"}, 32'(bus.stk_err), 32'h0);
    chk({tag, "_tmo_flg"}, 32'(bus.tmo_flg), 32'h0);
  endtask

  // br_vld at the current cycle t; returns at t+5 with the target issued
  task automatic go_branch(input logic [W_PC-1:0] tgt);
    bus.br_vld = 1'b1;
    bus.br_tgt = tgt;
    tick();
    bus.br_vld = 1'b0;
    chk("br_if_adr", 32'(bus.if_adr), 32'(tgt));
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) tick();
      chk("br_bubble", bus.instr, NOP);
    end
    tick();
    chk("br_target", bus.instr, w(tgt));
    chk("br_reg_ptr", 32'(bus.reg_ptr), 32'(tgt));
  endtask

  typedef struct {
    bit              pre_rst;
    bit              call;
    bit              ret;
    logic [W_PC-1:0] tgt;
    logic [W_PC-1:0] lnk;
    logic [W_PC-1:0] e_adr;
    logic [1:0]      e_lvl;
    bit              e_err;
  } vec_t;

  function automatic vec_t mk(bit pr, bit c, bit r, logic [W_PC-1:0] t, l, ea,
                              logic [1:0] el, bit ee);
    vec_t v;
    v.pre_rst = pr; v.call = c; v.ret = r; v.tgt = t; v.lnk = l;
    v.e_adr = ea; v.e_lvl = el; v.e_err = ee;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1);
  end

  initial begin
    tbl[0]  = mk(0, 0, 0, 16'h0055, 16'h0000, 16'h0055, 2'd0, 0);
    tbl[1]  = mk(0, 1, 0, 16'h0100, 16'h0001, 16'h0100, 2'd1, 0);
    tbl[2]  = mk(0, 1, 0, 16'h0101, 16'h0002, 16'h0101, 2'd2, 0);
    tbl[3]  = mk(0, 1, 0, 16'h0102, 16'h0003, 16'h0102, 2'd2, 1);
    tbl[4]  = mk(0, 0, 1, 16'h01FF, 16'h0000, 16'h0003, 2'd1, 1);
    tbl[5]  = mk(0, 0, 1, 16'h01FF, 16'h0000, 16'h0002, 2'd0, 1);
    tbl[6]  = mk(0, 0, 1, 16'h01FF, 16'h0000, 16'h0000, 2'd0, 1);
    tbl[7]  = mk(0, 0, 0, 16'h0066, 16'h0000, 16'h0066, 2'd0, 1);
    tbl[8]  = mk(1, 1, 0, 16'h0103, 16'h0010, 16'h0103, 2'd1, 0);
    tbl[9]  = mk(0, 1, 1, 16'h01FF, 16'h0020, 16'h0010, 2'd1, 0);
    tbl[10] = mk(0, 0, 1, 16'h01FF, 16'h0000, 16'h0020, 2'd0, 0);
    tbl[11] = mk(0, 1, 1, 16'h01FF, 16'h0030, 16'h0000, 2'd1, 1);
    tbl[12] = mk(0, 0, 1, 16'h01FF, 16'h0000, 16'h0030, 2'd0, 1);

    bus.f_rsm = 0; bus.f_cfg = 0; bus.cfg_ins = '0;
    bus.br_vld = 0; bus.br_tgt = '0; bus.br_call = 0; bus.br_ret = 0; bus.br_lnk = '0;

    // reset values
    tick(); tick();
    chk_reset_vals("rst");
    rst = 1'b0;

    // straight-line code from 0
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1) begin
        chk("first_ftc", 32'(bus.f_ftc), 32'h1);
        chk("first_adr", 32'(bus.if_adr), 32'h0);
      end
      if (c < 5) chk("fill_bubble", bus.instr, NOP);
      else begin
        chk("straight_instr", bus.instr, w(W_PC'(c-5)));
        chk("straight_ptr", 32'(bus.reg_ptr), 32'(c-5));
      end
    end

    // branch to 0x40
    go_branch(16'h0040);
    tick();
    chk("after_br", bus.instr, w(16'h0041));

    // flush flag at 0x21 restarts at 0x22
    fct_adr = 16'h0021;
    go_branch(16'h0020);
    tick();
    chk("fct_word", bus.instr, w(16'h0021));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("fct_bubble", bus.instr, NOP);
    end
    tick();
    chk("fct_next", bus.instr, w(16'h0022));
    chk("fct_ptr", 32'(bus.reg_ptr), 32'h22);
    fct_adr = 16'hFFFF;

    // hold at 7, resume 10 cycles later
    hold_adr = 16'h0007;
    go_branch(16'h0004);
    tick(); tick(); tick();
    chk("hold_word", bus.instr, w(16'h0007));
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("hold_f_hld", 32'(bus.f_hld), 32'h1);
      chk("hold_nop", bus.instr, NOP);
      if (k == 1) chk("hold_ftc", 32'(bus.f_ftc), 32'h0);
      if (k == 10) bus.f_rsm = 1'b1;
    end
    tick();
    bus.f_rsm = 1'b0;
    chk("rsm_f_hld", 32'(bus.f_hld), 32'h0);
    chk("rsm_nop", bus.instr, NOP);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("rsm_bubble", bus.instr, NOP);
    end
    tick();
    chk("rsm_word8", bus.instr, w(16'h0008));
    chk("rsm_ptr8", 32'(bus.reg_ptr), 32'h8);
    hold_adr = 16'hFFFF;

    // configuration override for 3 cycles
    tick(); tick();
    chk("cfg_pre", bus.instr, w(16'h000A));
    bus.f_cfg = 1'b1;
    bus.cfg_ins = 32'hC0DE_0000;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("cfg_instr", bus.instr, 32'hC0DE_0000 + 32'(k-1));
      chk("cfg_ptr_hold", 32'(bus.reg_ptr), 32'hA);
      if (k == 2) chk("cfg_ftc", 32'(bus.f_ftc), 32'h0);
      if (k < 3) bus.cfg_ins = 32'hC0DE_0000 + 32'(k);
      else bus.f_cfg = 1'b0;
    end
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("cfg_bubble", bus.instr, NOP);
    end
    tick();
    chk("cfg_resume", bus.instr, w(16'h000B));
    chk("cfg_resume_ptr", 32'(bus.reg_ptr), 32'hB);

    // return stack table
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].pre_rst) begin
        rst = 1'b1;
        #2;
        chk_reset_vals("midrst");
        tick();
        rst = 1'b0;
      end
      bus.br_vld  = 1'b1;
      bus.br_tgt  = tbl[i].tgt;
      bus.br_call = tbl[i].call;
      bus.br_ret  = tbl[i].ret;
      bus.br_lnk  = tbl[i].lnk;
      tick();
      bus.br_vld = 1'b0; bus.br_call = 1'b0; bus.br_ret = 1'b0;
      chk($sformatf("stk%0d_tgt", i), 32'(bus.if_adr), 32'(tbl[i].e_adr));
      chk($sformatf("stk%0d_lvl", i), 32'(bus.stk_lvl), 32'(tbl[i].e_lvl));
      chk($sformatf("stk%0d_err", i), 32'(bus.stk_err), 32'(tbl[i].e_err));
    end

`ifdef RTMQ_HOLD_WDT_EN
    // watchdog ends a hold after 2^W_TMO cycles
    hold_adr = 16'h0007;
    go_branch(16'h0004);
    tick(); tick(); tick();
    chk("wdt_word", bus.instr, w(16'h0007));
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("wdt_held", 32'(bus.f_hld), 32'h1);
    end
    tick();
    chk("wdt_release", 32'(bus.f_hld), 32'h0);
    chk("wdt_tmo_flg", 32'(bus.tmo_flg), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("wdt_bubble", bus.instr, NOP);
    end
    tick();
    chk("wdt_resume", bus.instr, w(16'h0008));
    // reset in the middle of a hold
    go_branch(16'h0004);
    tick(); tick(); tick();
    tick(); tick();
    chk("wdt2_held", 32'(bus.f_hld), 32'h1);
    rst = 1'b1;
    #2;
    chk_reset_vals("holdrst");
    tick();
    rst = 1'b0;
    hold_adr = 16'hFFFF;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
